// File: rtl/pp_pipeline_accel_fifo_wr_arb_if.sv
// Bus bundle between NUM_REQ ap_fifo-style producers, the write arbiter and
// the downstream shift-register FIFO write port.
// master: the arbiter side. slave: the producers plus the downstream FIFO.
interface pp_pipeline_accel_fifo_wr_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 19,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_din;
  logic [NUM_REQ-1:0]            req_full_n;
  logic                          fifo_full_n;
  logic                          fifo_write;
  logic [DATA_WIDTH-1:0]         fifo_din;
  logic [ID_WIDTH-1:0]           fifo_id;
  logic [NUM_REQ-1:0]            grant;

  modport master (
    input  req_write, req_din, fifo_full_n,
    output req_full_n, fifo_write, fifo_din, fifo_id, grant
  );

  modport slave (
    output req_write, req_din, fifo_full_n,
    input  req_full_n, fifo_write, fifo_din, fifo_id, grant
  );
endinterface

// File: rtl/pp_pipeline_accel_fifo_wr_arb.sv
// Round-robin write arbiter: shares one downstream FIFO write port between
// NUM_REQ producers, holding each grant for at most BURST_LEN beats.
// The datapath is a combinational mux steered by the registered grant.
module pp_pipeline_accel_fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 19,
  parameter int BURST_LEN  = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic clk,
  input  logic reset,
  pp_pipeline_accel_fifo_wr_arb_if.master bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [NUM_REQ-1:0] grant_q;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   burst_cnt;

  logic [PTR_W-1:0]      owner;
  logic [DATA_WIDTH-1:0] owner_din;
  logic                  owner_write;
  logic                  xfer;
  logic                  release_now;
  logic [PTR_W-1:0]      next_ptr;
  logic [PTR_W-1:0]      sel_idle;
  logic [PTR_W-1:0]      sel_rel;

  // First requester at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [PTR_W-1:0]   ptr);
    int idx;
    rr_pick = '0;
    // Walk from the farthest slot back so the nearest hit is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) rr_pick = PTR_W'(idx);
    end
  endfunction

  // Decode the owner of the grant and mux its data onto the FIFO port.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    owner     = '0;
    owner_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner     = PTR_W'(i);
        owner_din = bus.req_din[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign owner_write = |(grant_q & bus.req_write);
  // Outputs are suppressed while reset is high so no beat moves during reset.
  assign bus.fifo_write = owner_write & ~reset;
  assign bus.fifo_din   = owner_din;
  assign bus.fifo_id    = ID_WIDTH'(owner);
  assign bus.req_full_n = grant_q & {NUM_REQ{bus.fifo_full_n & ~reset}};
  assign bus.grant      = grant_q;

  assign xfer        = bus.fifo_write & bus.fifo_full_n;
  assign release_now = (xfer && burst_cnt == CNT_W'(BURST_LEN - 1)) || !owner_write;
  assign next_ptr    = (int'(owner) == NUM_REQ - 1) ? '0 : owner + PTR_W'(1);
  assign sel_idle    = rr_pick(bus.req_write, rr_ptr);
  // The old owner sits last in the rotated search, so it only wins when alone.
  assign sel_rel     = rr_pick(bus.req_write, next_ptr);

  // Arbitration FSM: grant, burst counting and pointer rotation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state     <= IDLE;
      grant_q   <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_write) begin
            grant_q   <= NUM_REQ'(1) << sel_idle;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            rr_ptr <= next_ptr;
            if (|bus.req_write) begin
              grant_q   <= NUM_REQ'(1) << sel_rel;
              burst_cnt <= '0;
            end else begin
              grant_q <= '0;
              state   <= IDLE;
            end
          end else if (xfer) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        default: begin
          grant_q <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
